// File: rtl/ppu_spr.sv
// NES PPU sprite generator: 64-entry OAM, per-scanline sprite evaluation during
// horizontal blank, pattern fetch into eight staging slots, and live pixel shifters.
module ppu_spr (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        en_in,
  input  logic        ls_clip_in,
  input  logic        spr_h_in,
  input  logic        spr_pt_sel_in,
  input  logic [7:0]  oam_a_in,
  input  logic [7:0]  oam_d_in,
  input  logic        oam_wr_in,
  input  logic [9:0]  nes_x_in,
  input  logic [9:0]  nes_y_next_in,
  input  logic        pix_pulse_in,
  input  logic [7:0]  vram_d_in,
  output logic [7:0]  oam_d_out,
  output logic [13:0] vram_a_out,
  output logic        vram_req_out,
  output logic [3:0]  palette_idx_out,
  output logic        pri_out,
  output logic        spr_0_out,
  output logic        overflow_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_FETCH_LO_A,
    S_FETCH_LO_D,
    S_FETCH_HI_A,
    S_FETCH_HI_D
  } state_t;

  state_t state, state_nxt;

  // OAM: attribute keeps only {vflip, hflip, priority, palette[1:0]}
  logic [7:0] oam_y    [64];
  logic [7:0] oam_tile [64];
  logic [4:0] oam_attr [64];
  logic [7:0] oam_x    [64];
  logic [5:0] oam_n;
  logic [7:0] rd_byte;

  assign oam_n = oam_a_in[7:2];

  always_ff @(posedge clk_in) begin
    if (oam_wr_in) begin
      case (oam_a_in[1:0])
        2'd0:    oam_y[oam_n]    <= oam_d_in;
        2'd1:    oam_tile[oam_n] <= oam_d_in;
        2'd2:    oam_attr[oam_n] <= {oam_d_in[7:5], oam_d_in[1:0]};
        default: oam_x[oam_n]    <= oam_d_in;
      endcase
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (oam_a_in[1:0])
      2'd0:    rd_byte = oam_y[oam_n];
      2'd1:    rd_byte = oam_tile[oam_n];
      2'd2:    rd_byte = {oam_attr[oam_n][4:2], 3'b000, oam_attr[oam_n][1:0]};
      default: rd_byte = oam_x[oam_n];
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) oam_d_out <= 8'h00;
    else           oam_d_out <= rd_byte;
  end

  // Evaluation and fetch bookkeeping
  logic [5:0] idx;
  logic [3:0] cnt;
  logic [2:0] slot;
  logic [8:0] ev_row9;
  logic [8:0] hgt9;
  logic       ev_hit;
  logic       start;
  logic       fetching;

  assign ev_row9  = {1'b0, nes_y_next_in[7:0]} - ({1'b0, oam_y[idx]} + 9'd1);
  assign hgt9     = spr_h_in ? 9'd16 : 9'd8;
  assign ev_hit   = (ev_row9 < hgt9);
  assign start    = (state == S_IDLE) && pix_pulse_in && (nes_x_in == 10'd256) &&
                    (nes_y_next_in < 10'd240) && en_in;
  assign fetching = (state == S_FETCH_LO_A) || (state == S_FETCH_LO_D) ||
                    (state == S_FETCH_HI_A) || (state == S_FETCH_HI_D);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start) state_nxt = S_EVAL;
      S_EVAL:       if (!en_in) state_nxt = S_IDLE;
                    else if (idx == 6'd63) state_nxt = S_FETCH_LO_A;
      S_FETCH_LO_A: state_nxt = en_in ? S_FETCH_LO_D : S_IDLE;
      S_FETCH_LO_D: state_nxt = en_in ? S_FETCH_HI_A : S_IDLE;
      S_FETCH_HI_A: state_nxt = en_in ? S_FETCH_HI_D : S_IDLE;
      S_FETCH_HI_D: state_nxt = (!en_in || slot == 3'd7) ? S_IDLE : S_FETCH_LO_A;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Staging slots filled during evaluation and fetch
  logic [7:0] stg_tile [8];
  logic [4:0] stg_attr [8];
  logic [7:0] stg_x    [8];
  logic [3:0] stg_row  [8];
  logic       stg_s0   [8];
  logic [7:0] stg_lo   [8];
  logic [7:0] stg_hi   [8];

  // vram bus: vram_a_out is meaningful only while vram_req_out is high; the
  // byte for an address returns on vram_d_in the following clk (*_D state).
  logic [3:0] r_eff;
  logic       plane;
  logic [7:0] f_tile;
  logic [4:0] f_attr;
  logic [7:0] d_rev;
  logic [7:0] f_byte;

  assign f_tile = stg_tile[slot];
  assign f_attr = stg_attr[slot];
  assign r_eff  = f_attr[4] ? ((spr_h_in ? 4'd15 : 4'd7) - stg_row[slot]) : stg_row[slot];
  assign plane  = (state == S_FETCH_HI_A) || (state == S_FETCH_HI_D);

  always_comb begin
    d_rev = 8'h00;
    for (int i = 0; i < 8; i++) d_rev[i] = vram_d_in[7-i];
  end

  assign f_byte = ({1'b0, slot} < cnt) ? (f_attr[3] ? d_rev : vram_d_in) : 8'h00;

  always_comb begin
    vram_a_out = 14'h0000;
    if (fetching) begin
      if (spr_h_in) vram_a_out = {1'b0, f_tile[0], f_tile[7:1], r_eff[3], plane, r_eff[2:0]};
      else          vram_a_out = {1'b0, spr_pt_sel_in, f_tile, plane, r_eff[2:0]};
    end
  end

  assign vram_req_out = fetching;

  always_ff @(posedge clk_in) begin
    if (state == S_EVAL && en_in && ev_hit && cnt < 4'd8) begin
      stg_tile[cnt[2:0]] <= oam_tile[idx];
      stg_attr[cnt[2:0]] <= oam_attr[idx];
      stg_x[cnt[2:0]]    <= oam_x[idx];
      stg_row[cnt[2:0]]  <= ev_row9[3:0];
      stg_s0[cnt[2:0]]   <= (idx == 6'd0);
    end
    if (state == S_FETCH_LO_D) stg_lo[slot] <= f_byte;
    if (state == S_FETCH_HI_D) stg_hi[slot] <= f_byte;
  end

  // Live shifters: {priority, palette[1:0]} per slot in live_pa
  logic [7:0] live_lo [8];
  logic [7:0] live_hi [8];
  logic [7:0] live_x  [8];
  logic [2:0] live_pa [8];
  logic       live_s0 [8];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      idx          <= 6'd0;
      cnt          <= 4'd0;
      slot         <= 3'd0;
      overflow_out <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        live_lo[i] <= 8'h00;
        live_hi[i] <= 8'h00;
        live_x[i]  <= 8'h00;
        live_pa[i] <= 3'b000;
        live_s0[i] <= 1'b0;
      end
    end else begin
      if (start) begin
        idx  <= 6'd0;
        cnt  <= 4'd0;
        slot <= 3'd0;
        if (nes_y_next_in == 10'd0) overflow_out <= 1'b0;
      end
      if (state == S_EVAL && en_in) begin
        idx <= idx + 6'd1;
        if (ev_hit) begin
          if (cnt < 4'd8) cnt <= cnt + 4'd1;
          else            overflow_out <= 1'b1;
        end
      end
      if (state == S_FETCH_HI_D && en_in) slot <= slot + 3'd1;
      if (pix_pulse_in && nes_x_in < 10'd256) begin
        for (int i = 0; i < 8; i++) begin
          if (live_x[i] != 8'h00) live_x[i] <= live_x[i] - 8'h01;
          else begin
            live_lo[i] <= {live_lo[i][6:0], 1'b0};
            live_hi[i] <= {live_hi[i][6:0], 1'b0};
          end
        end
      end
      // Slot 7's high byte is still on vram_d_in, so it bypasses staging
      if (state == S_FETCH_HI_D && slot == 3'd7 && en_in) begin
        for (int i = 0; i < 8; i++) begin
          live_lo[i] <= stg_lo[i];
          live_hi[i] <= (i == 7) ? f_byte : stg_hi[i];
          live_x[i]  <= stg_x[i];
          live_pa[i] <= stg_attr[i][2:0];
          live_s0[i] <= stg_s0[i] && (4'(i) < cnt);
        end
      end
      if (!en_in && state != S_IDLE) begin
        for (int i = 0; i < 8; i++) begin
          live_lo[i] <= 8'h00;
          live_hi[i] <= 8'h00;
          live_x[i]  <= 8'h00;
          live_pa[i] <= 3'b000;
          live_s0[i] <= 1'b0;
        end
      end
    end
  end

  // Priority: lowest-index slot with an opaque pixel wins
  logic [1:0] px [8];
  logic [3:0] win_pal;
  logic       win_pri;
  logic       s0_hit;
  logic       blank;

  always_comb begin
    win_pal = 4'h0;
    win_pri = 1'b0;
    for (int i = 0; i < 8; i++)
      px[i] = (live_x[i] == 8'h00) ? {live_hi[i][7], live_lo[i][7]} : 2'b00;
    for (int i = 7; i >= 0; i--) begin
      if (px[i] != 2'b00) begin
        win_pal = {live_pa[i][1:0], px[i]};
        win_pri = live_pa[i][2];
      end
    end
    s0_hit = live_s0[0] && (px[0] != 2'b00);
  end

  assign blank = (ls_clip_in && nes_x_in < 10'd8) || (nes_x_in >= 10'd256) || !en_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || !en_in) begin
      palette_idx_out <= 4'h0;
      pri_out         <= 1'b0;
      spr_0_out       <= 1'b0;
    end else if (pix_pulse_in) begin
      palette_idx_out <= blank ? 4'h0 : win_pal;
      pri_out         <= blank ? 1'b0 : win_pri;
      spr_0_out       <= blank ? 1'b0 : s0_hit;
    end
  end

endmodule

// File: tb/tb_ppu_spr.sv
// Directed bench for ppu_spr: OAM access, evaluation/fetch addressing, pixel output
// positions, priority, clipping, overflow, enable abort and mid-fetch reset.
module tb_ppu_spr;

  logic        clk_in = 1'b0;
  logic        rst_n_in, en_in, ls_clip_in, spr_h_in, spr_pt_sel_in;
  logic [7:0]  oam_a_in, oam_d_in;
  logic        oam_wr_in;
  logic [9:0]  nes_x_in, nes_y_next_in;
  logic        pix_pulse_in;
  logic [7:0]  vram_d_in;
  logic [7:0]  oam_d_out;
  logic [13:0] vram_a_out;
  logic        vram_req_out;
  logic [3:0]  palette_idx_out;
  logic        pri_out, spr_0_out, overflow_out;

  ppu_spr dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .ls_clip_in(ls_clip_in),
    .spr_h_in(spr_h_in), .spr_pt_sel_in(spr_pt_sel_in), .oam_a_in(oam_a_in),
    .oam_d_in(oam_d_in), .oam_wr_in(oam_wr_in), .nes_x_in(nes_x_in),
    .nes_y_next_in(nes_y_next_in), .pix_pulse_in(pix_pulse_in), .vram_d_in(vram_d_in),
    .oam_d_out(oam_d_out), .vram_a_out(vram_a_out), .vram_req_out(vram_req_out),
    .palette_idx_out(palette_idx_out), .pri_out(pri_out), .spr_0_out(spr_0_out),
    .overflow_out(overflow_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  // Video memory model: one-clk read latency
  logic [7:0] vmem [0:16383];
  always @(posedge clk_in) vram_d_in <= vmem[vram_a_out];

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q [$];

  logic [3:0]  pal_a [256];
  logic        pri_a [256];
  logic        s0_a  [256];
  logic [13:0] addr_a [32];
  int          req_first, req_cnt;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } oam_vec_t;

  typedef struct packed {
    logic [3:0] scen;
    logic [8:0] x;
    logic [3:0] pal;
    logic       pri;
    logic       s0;
  } pix_vec_t;

  oam_vec_t oam_tab [$];
  pix_vec_t pix_tab [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic oam_wr(input logic [7:0] a, input logic [7:0] d);
    oam_a_in  = a;
    oam_d_in  = d;
    oam_wr_in = 1'b1;
    tick();
    oam_wr_in = 1'b0;
  endtask

  task automatic set_spr(input int n, input logic [7:0] y, input logic [7:0] tile,
                         input logic [7:0] attr, input logic [7:0] x);
    oam_wr(8'(n * 4 + 0), y);
    oam_wr(8'(n * 4 + 1), tile);
    oam_wr(8'(n * 4 + 2), attr);
    oam_wr(8'(n * 4 + 3), x);
  endtask

  task automatic clear_oam;
    for (int i = 0; i < 64; i++) set_spr(i, 8'hFF, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic trigger(input logic [9:0] y);
    nes_y_next_in = y;
    nes_x_in      = 10'd256;
    pix_pulse_in  = 1'b1;
    tick();
    pix_pulse_in  = 1'b0;
  endtask

  task automatic run_line(input logic [9:0] y);
    trigger(y);
    req_first = -1;
    req_cnt   = 0;
    for (int j = 0; j < 100; j++) begin
      if (vram_req_out) begin
        if (req_first < 0) req_first = j;
        if (req_cnt < 32) addr_a[req_cnt] = vram_a_out;
        req_cnt++;
      end
      tick();
    end
    for (int x = 0; x < 256; x++) begin
      nes_x_in     = 10'(x);
      pix_pulse_in = 1'b1;
      tick();
      pal_a[x] = palette_idx_out;
      pri_a[x] = pri_out;
      s0_a[x]  = spr_0_out;
    end
    pix_pulse_in = 1'b0;
    nes_x_in     = 10'd256;
  endtask

  task automatic check_pix(input logic [3:0] scen);
    foreach (pix_tab[k]) begin
      if (pix_tab[k].scen == scen) begin
        chk($sformatf("s%0d_pix_x%0d", scen, pix_tab[k].x),
            {26'd0, pal_a[pix_tab[k].x], pri_a[pix_tab[k].x], s0_a[pix_tab[k].x]},
            {26'd0, pix_tab[k].pal, pix_tab[k].pri, pix_tab[k].s0});
      end
    end
  endtask

  task automatic check_addrs(input string name, input int slot);
    logic [13:0] e;
    e = exp_q.pop_front();
    chk({name, "_lo"}, 32'(addr_a[slot * 4]), 32'(e));
    e = exp_q.pop_front();
    chk({name, "_hi"}, 32'(addr_a[slot * 4 + 2]), 32'(e));
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
    rst_n_in = 1'b0; en_in = 1'b1; ls_clip_in = 1'b0; spr_h_in = 1'b0;
    spr_pt_sel_in = 1'b0; oam_a_in = 8'h00; oam_d_in = 8'h00; oam_wr_in = 1'b0;
    nes_x_in = 10'd256; nes_y_next_in = 10'd0; pix_pulse_in = 1'b0;

    // OAM vectors: {address, write data, expected read-back}
    oam_tab.push_back('{8'h00, 8'h5A, 8'h5A});
    oam_tab.push_back('{8'h02, 8'hFF, 8'hE3});
    oam_tab.push_back('{8'h06, 8'h1C, 8'h00});
    oam_tab.push_back('{8'h81, 8'h3C, 8'h3C});
    oam_tab.push_back('{8'hFF, 8'hA5, 8'hA5});
    // Pixel vectors: {scenario, nes_x, palette_idx, pri, spr_0}
    pix_tab.push_back('{4'd1, 9'd19,  4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd1, 9'd20,  4'h9, 1'b0, 1'b1});
    pix_tab.push_back('{4'd1, 9'd21,  4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd2, 9'd20,  4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd2, 9'd26,  4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd2, 9'd27,  4'h9, 1'b0, 1'b1});
    pix_tab.push_back('{4'd3, 9'd0,   4'h3, 1'b0, 1'b1});
    pix_tab.push_back('{4'd3, 9'd60,  4'hB, 1'b0, 1'b0});
    pix_tab.push_back('{4'd3, 9'd210, 4'hF, 1'b0, 1'b0});
    pix_tab.push_back('{4'd3, 9'd240, 4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd4, 9'd100, 4'h1, 1'b0, 1'b0});
    pix_tab.push_back('{4'd4, 9'd101, 4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd5, 9'd0,   4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd5, 9'd7,   4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd5, 9'd8,   4'h0, 1'b0, 1'b0});
    pix_tab.push_back('{4'd5, 9'd50,  4'h5, 1'b1, 1'b0});
    pix_tab.push_back('{4'd6, 9'd3,   4'h1, 1'b0, 1'b1});
    pix_tab.push_back('{4'd6, 9'd50,  4'h5, 1'b1, 1'b0});

    tick(); tick();
    chk("rst_pal", 32'(palette_idx_out), 32'h0);
    chk("rst_pri", 32'(pri_out), 32'h0);
    chk("rst_s0", 32'(spr_0_out), 32'h0);
    chk("rst_ovf", 32'(overflow_out), 32'h0);
    chk("rst_req", 32'(vram_req_out), 32'h0);
    chk("rst_vaddr", 32'(vram_a_out), 32'h0);
    chk("rst_oam_d", 32'(oam_d_out), 32'h0);
    rst_n_in = 1'b1;
    tick();

    foreach (oam_tab[k]) oam_wr(oam_tab[k].a, oam_tab[k].d);
    foreach (oam_tab[k]) begin
      oam_a_in = oam_tab[k].a;
      tick();
      chk($sformatf("oam_rd_%0h", oam_tab[k].a), 32'(oam_d_out), 32'(oam_tab[k].exp));
    end
    // Same-clk write and read returns the old byte
    oam_wr(8'h44, 8'h11);
    oam_a_in = 8'h44; oam_d_in = 8'h22; oam_wr_in = 1'b1;
    tick();
    oam_wr_in = 1'b0;
    chk("oam_rw_old", 32'(oam_d_out), 32'h11);
    tick();
    chk("oam_rw_new", 32'(oam_d_out), 32'h22);

    clear_oam();

    // Basic sprite 0
    set_spr(0, 8'd9, 8'h01, 8'h02, 8'd20);
    vmem[14'h0010] = 8'h80;
    run_line(10'd10);
    chk("req_first", 32'(req_first), 32'd64);
    chk("req_cnt", 32'(req_cnt), 32'd32);
    exp_q.push_back(14'h0010); exp_q.push_back(14'h0018);
    check_addrs("s1_addr", 0);
    check_pix(4'd1);
    chk("s1_ovf", 32'(overflow_out), 32'h0);

    // Horizontal flip
    set_spr(0, 8'd9, 8'h01, 8'h42, 8'd20);
    run_line(10'd10);
    check_pix(4'd2);

    // Nine sprites on one line
    clear_oam();
    for (int i = 0; i < 9; i++) begin
      set_spr(i, 8'd49, 8'(16 + i), 8'(i % 4), 8'(30 * i));
      vmem[(16 + i) * 16]     = 8'h80;
      vmem[(16 + i) * 16 + 8] = 8'h80;
    end
    run_line(10'd50);
    chk("s3_ovf_set", 32'(overflow_out), 32'h1);
    exp_q.push_back(14'h0170); exp_q.push_back(14'h0178);
    check_addrs("s3_slot7", 7);
    check_pix(4'd3);
    clear_oam();
    run_line(10'd100);
    chk("s3_ovf_hold", 32'(overflow_out), 32'h1);
    run_line(10'd0);
    chk("s3_ovf_clr", 32'(overflow_out), 32'h0);

    // 8x16 with vertical flip, row 0
    spr_h_in = 1'b1;
    set_spr(3, 8'd19, 8'h03, 8'h80, 8'd100);
    vmem[14'h1037] = 8'h80;
    run_line(10'd20);
    exp_q.push_back(14'h1037); exp_q.push_back(14'h103F);
    check_addrs("s4_addr", 0);
    check_pix(4'd4);
    spr_h_in = 1'b0;
    clear_oam();

    // Overlap priority and left clip
    set_spr(0, 8'd59, 8'h24, 8'h00, 8'd0);
    set_spr(2, 8'd59, 8'h20, 8'h21, 8'd50);
    set_spr(5, 8'd59, 8'h21, 8'h03, 8'd50);
    vmem[14'h0240] = 8'hFF;
    vmem[14'h0200] = 8'h80;
    vmem[14'h0210] = 8'h80;
    ls_clip_in = 1'b1;
    run_line(10'd60);
    check_pix(4'd5);
    ls_clip_in = 1'b0;
    run_line(10'd60);
    check_pix(4'd6);

    // Enable drop mid-fetch
    trigger(10'd60);
    repeat (70) tick();
    chk("abort_req_before", 32'(vram_req_out), 32'h1);
    en_in = 1'b0;
    tick();
    chk("abort_req_after", 32'(vram_req_out), 32'h0);
    en_in = 1'b1;
    tick();

    // Reset pulse mid-fetch
    oam_a_in = 8'h15;
    trigger(10'd60);
    repeat (70) tick();
    chk("rstf_req_before", 32'(vram_req_out), 32'h1);
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    chk("rstf_req", 32'(vram_req_out), 32'h0);
    chk("rstf_vaddr", 32'(vram_a_out), 32'h0);
    chk("rstf_outs", {28'd0, palette_idx_out} | {31'd0, pri_out} | {31'd0, spr_0_out}, 32'h0);
    chk("rstf_ovf", 32'(overflow_out), 32'h0);
    tick();
    chk("rstf_oam_d", 32'(oam_d_out), 32'h21);
    repeat (40) tick();
    chk("rstf_idle", 32'(vram_req_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
